uart_axil_bridge: RTL and testbench
===================================

UART_AXIL_BRIDGE -- requirements
Module: uart_axil_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX and TX FIFO depth in bytes; power of 2, minimum 2.
REQ-002 Parameter ADDR_W, default 4, AXI-Lite address width; RX register 0x0, TX register 0x4, status register 0x8, zero-extended.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 m_araddr  out  ADDR_W  read address.
REQ-006 m_arvalid  out  1  read address valid.
REQ-007 m_arready  in  1  read address ready.
REQ-008 m_rdata  in  32  read data.
REQ-009 m_rresp  in  2  read response.
REQ-010 m_rvalid  in  1  read data valid.
REQ-011 m_rready  out  1  read data ready.
REQ-012 m_awaddr  out  ADDR_W  write address.
REQ-013 m_awvalid  out  1  write address valid.
REQ-014 m_awready  in  1  write address ready.
REQ-015 m_wdata  out  32  write data; byte in [7:0], upper bits 0.
REQ-016 m_wstrb  out  4  write strobe; fixed at 4'b0001.
REQ-017 m_wvalid  out  1  write data valid.
REQ-018 m_wready  in  1  write data ready.
REQ-019 m_bresp  in  2  write response.
REQ-020 m_bvalid  in  1  write response valid.
REQ-021 m_bready  out  1  write response ready.
REQ-022 rx_data  out  8  received byte at the RX FIFO head.
REQ-023 rx_valid  out  1  RX FIFO not empty.
REQ-024 rx_ready  in  1  CPU pops the RX byte when rx_valid and rx_ready are both high.
REQ-025 tx_data  in  8  byte to transmit.
REQ-026 tx_valid  in  1  CPU push request.
REQ-027 tx_ready  out  1  TX FIFO not full; the byte is pushed when tx_valid and tx_ready are both high.
REQ-028 err  out  1  sticky flag; set when any RRESP or BRESP is nonzero.

Function
REQ-029 FSM states: IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_W, TX_B; the FSM has only one AXI transaction outstanding at a time.
REQ-030 IDLE moves to ST_AR on the next cycle when the RX FIFO is not full or the TX FIFO is not empty; otherwise the FSM stays in IDLE.
REQ-031 ST_AR drives araddr=0x8 and arvalid=1 and holds both until arready; on the handshake cycle arvalid drops and the FSM enters ST_R.
REQ-032 ST_R, RX_R: rready=1 until rvalid; the data word is captured on the handshake, rready drops next cycle.
REQ-033 After ST_R: candidate RX if status[0]=1 and RX FIFO not full; candidate TX if status[3]=0 and TX FIFO not empty.
REQ-034 If both are candidates, a round-robin bit picks the winner and then toggles; RX wins first after reset; if there is no candidate, the FSM returns to IDLE.
REQ-035 RX_AR/RX_R read address 0x0; rdata[7:0] is pushed into the RX FIFO on the R handshake, then IDLE.
REQ-036 TX_W asserts awvalid (awaddr=0x4) and wvalid (wdata = TX head) together; each drops independently on its own ready; the state exits when both are done, in either order or the same cycle.
REQ-037 TX_B: bready=1 until bvalid; the TX head is popped on the B handshake, then IDLE.
REQ-038 The TX byte is popped even if BRESP is nonzero (err set, no retry); the RX byte is pushed even if RRESP is nonzero.
REQ-039 Each FIFO supports simultaneous push and pop in one cycle, including when full with pop and when empty with push; pointers wrap modulo FIFO_DEPTH; a count of FIFO_DEPTH means full.
REQ-040 rx_valid/rx_data and tx_ready are derived from registered FIFO state only, with no combinational path from AXI inputs.
REQ-041 Pushing to a full FIFO or popping from an empty FIFO has no effect.

Reset
REQ-042 While RST_N=0: FSM in IDLE, FIFOs empty, round-robin bit selects RX, err=0, all AXI valid/ready outputs 0, addresses and wdata 0; rx_valid=0, tx_ready=1 from the first cycle after release.
REQ-043 Reset during any state aborts the transaction immediately; no FIFO is modified on that cycle.

Verification
REQ-044 Status 0x01, RX reg 0x41, slave ready stalls of 0..3 cycles -> rx_valid high with rx_data=0x41; exactly one 0x0 read per status poll.
REQ-045 Push 3 bytes 0x10,0x11,0x12, status 0x00 -> three writes to 0x4 in order, wstrb=0001, AW/W accepted in skewed and same-cycle order.
REQ-046 Status 0x08 with TX FIFO non-empty -> no AW issued, repeated status polls, FIFO contents retained.
REQ-047 Status 0x01 with TX pending -> RX read and TX write alternate starting with RX; fill RX FIFO to FIFO_DEPTH with rx_ready=0 -> no further 0x0 reads.
REQ-048 BRESP=2'b10 on a write -> err=1 and held, byte popped; then RST_N=0 mid-TX_W -> all valids 0, err=0 next cycle.

Source files
------------

// File: rtl/uart_axil_bridge.sv
// AXI-Lite master that polls a memory-mapped UART and moves bytes between its
// RX/TX data registers and a pair of local byte FIFOs facing the CPU.
module uart_axil_bridge #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              RST_N,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [31:0]       m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [7:0]        tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]     FULL_CNT    = FIFO_DEPTH[CW-1:0];
   localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8);

   typedef enum logic [2:0] {IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_W, TX_B} state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;
   logic          err_q, err_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [7:0]    tx_mem_q [FIFO_DEPTH];

   logic rx_full, rx_empty, tx_full, tx_empty;
   logic rx_push, rx_push_ok, rx_pop_ok;
   logic tx_pop, tx_pop_ok, tx_push_ok;
   logic rx_cand, tx_cand;
   logic unused_rdata;

   assign unused_rdata = ^m_rdata[31:8];

   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);

   assign rx_valid = !rx_empty;
   assign rx_data  = rx_mem_q[rx_rd_ptr_q];
   assign tx_ready = !tx_full;
   assign err      = err_q;

   // Outputs are gated by RST_N so a reset aborts the transaction in the same cycle.
   assign m_arvalid = RST_N && (state_q == ST_AR || state_q == RX_AR);
   assign m_araddr  = (RST_N && state_q == ST_AR) ? ADDR_STATUS : '0;
   assign m_rready  = RST_N && (state_q == ST_R || state_q == RX_R);
   assign m_awvalid = RST_N && state_q == TX_W && !aw_done_q;
   assign m_awaddr  = (RST_N && state_q == TX_W) ? ADDR_TX : '0;
   assign m_wvalid  = RST_N && state_q == TX_W && !w_done_q;
   assign m_wdata   = (RST_N && state_q == TX_W) ? {24'h0, tx_mem_q[tx_rd_ptr_q]} : 32'h0;
   assign m_wstrb   = 4'b0001;
   assign m_bready  = RST_N && state_q == TX_B;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      err_d     = err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rx_push   = 1'b0;
      tx_pop    = 1'b0;
      rx_cand   = 1'b0;
      tx_cand   = 1'b0;
      case (state_q)
         IDLE:  if (!rx_full || !tx_empty) state_d = ST_AR;
         ST_AR: if (m_arready) state_d = ST_R;
         ST_R: begin
            if (m_rvalid) begin
               rx_cand = m_rdata[0] && !rx_full;
               tx_cand = !m_rdata[3] && !tx_empty;
               if (rx_cand && tx_cand) begin
                  state_d = rr_q ? TX_W : RX_AR;
                  rr_d    = !rr_q;
               end else if (rx_cand) begin
                  state_d = RX_AR;
               end else if (tx_cand) begin
                  state_d = TX_W;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RX_AR: if (m_arready) state_d = RX_R;
         RX_R: begin
            if (m_rvalid) begin
               rx_push = 1'b1;
               state_d = IDLE;
            end
         end
         TX_W: begin
            aw_done_d = aw_done_q || m_awready;
            w_done_d  = w_done_q || m_wready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = TX_B;
            end
         end
         TX_B: begin
            if (m_bvalid) begin
               tx_pop  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (m_rvalid && m_rready && m_rresp != 2'b00) err_d = 1'b1;
      if (m_bvalid && m_bready && m_bresp != 2'b00) err_d = 1'b1;
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
   always_comb begin
      rx_pop_ok   = rx_ready && !rx_empty;
      rx_push_ok  = rx_push && (!rx_full || rx_pop_ok);
      tx_pop_ok   = tx_pop && !tx_empty;
      tx_push_ok  = tx_valid && tx_ready;
      rx_wr_ptr_d = rx_wr_ptr_q + PW'(rx_push_ok);
      rx_rd_ptr_d = rx_rd_ptr_q + PW'(rx_pop_ok);
      rx_cnt_d    = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
      tx_wr_ptr_d = tx_wr_ptr_q + PW'(tx_push_ok);
      tx_rd_ptr_d = tx_rd_ptr_q + PW'(tx_pop_ok);
      tx_cnt_d    = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop_ok);
   end

   always_ff @(posedge clk) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         err_q       <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         err_q       <= err_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_cnt_q    <= tx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (RST_N && rx_push_ok) rx_mem_q[rx_wr_ptr_q] <= m_rdata[7:0];
      if (RST_N && tx_push_ok) tx_mem_q[tx_wr_ptr_q] <= tx_data;
   end
endmodule

// File: tb/tb_uart_axil_bridge.sv
// Randomized bench: an AXI-Lite UART slave model with random ready/valid stalls and
// queue-based expectations for the RX and TX byte streams.
module tb_uart_axil_bridge;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          RST_N;
   logic [AW-1:0] m_araddr, m_awaddr;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0]   m_rdata, m_wdata;
   logic [1:0]    m_rresp, m_bresp;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [3:0]    m_wstrb;
   logic [7:0]    rx_data, tx_data;
   logic          rx_valid, rx_ready, tx_valid, tx_ready, err;

   always #5 clk = ~clk;

   uart_axil_bridge #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .RST_N(RST_N),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // slave configuration and reference model state
   logic [7:0] status_cfg = 8'h00;
   logic [1:0] rresp_cfg  = 2'b00;
   logic [1:0] bresp_cfg  = 2'b00;
   bit         slave_en   = 1'b1;
   bit         wr_hold    = 1'b0;
   bit         first_rx   = 1'b0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];
   int         ops[$];
   int         n_status = 0, n_rxrd = 0, n_wr = 0;

   int          ar_wait, r_wait, aw_wait, w_wait, b_wait, prev_ar;
   bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
   logic [AW-1:0] last_ar;
   logic [31:0] rnd;
   logic [7:0]  rx_byte;

   // Slave: drives on the falling edge; a handshake flagged here completes at the next rising edge.
   always @(negedge clk) begin
      if (!RST_N) begin
         m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
         ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
         r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; prev_ar = -1; last_ar = '0;
         ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 3);
         w_wait  = $urandom_range(0, 3); r_wait  = 0; b_wait = 0;
      end else begin
         if (ar_hs) begin
            m_arready = 0; r_pend = 1;
            r_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
         end
         if (r_hs) begin m_rvalid = 0; m_rdata = 0; m_rresp = 0; end
         if (aw_hs) begin m_awready = 0; aw_got = 1; aw_wait = $urandom_range(0, 3); end
         if (w_hs) begin m_wready = 0; w_got = 1; w_wait = $urandom_range(0, 3); end
         if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = $urandom_range(0, 3); end
         if (b_hs) begin m_bvalid = 0; m_bresp = 0; end
         if (slave_en) begin
            if (m_arvalid && !m_arready) begin
               if (ar_wait == 0) m_arready = 1; else ar_wait--;
            end
            if (r_pend) begin
               if (r_wait == 0) begin
                  rnd = $urandom();
                  if (last_ar == AW'(8)) begin
                     m_rdata = {rnd[31:8], status_cfg};
                  end else begin
                     rx_byte  = first_rx ? 8'h41 : 8'($urandom_range(0, 255));
                     first_rx = 0;
                     m_rdata  = {rnd[31:8], rx_byte};
                  end
                  m_rresp = rresp_cfg; m_rvalid = 1; r_pend = 0;
               end else r_wait--;
            end
            if (!wr_hold && m_awvalid && !m_awready) begin
               if (aw_wait == 0) m_awready = 1; else aw_wait--;
            end
            if (!wr_hold && m_wvalid && !m_wready) begin
               if (w_wait == 0) m_wready = 1; else w_wait--;
            end
            if (b_pend) begin
               if (b_wait == 0) begin m_bvalid = 1; m_bresp = bresp_cfg; b_pend = 0; end
               else b_wait--;
            end
         end
         ar_hs = m_arvalid && m_arready;
         r_hs  = m_rvalid && m_rready;
         aw_hs = m_awvalid && m_awready;
         w_hs  = m_wvalid && m_wready;
         b_hs  = m_bvalid && m_bready;
         if (ar_hs) begin
            check("ar_addr_legal", 32'(m_araddr == AW'(0) || m_araddr == AW'(8)), 1);
            if (m_araddr == AW'(0)) begin
               check("one_rx_read_per_poll", prev_ar, 8);
               ops.push_back(0);
               n_rxrd++;
            end else n_status++;
            last_ar = m_araddr;
            prev_ar = int'(m_araddr);
         end
         if (r_hs && last_ar == AW'(0)) begin
            exp_rx.push_back(m_rdata[7:0]);
            $display("rx_read  data=0x%02h", m_rdata[7:0]);
         end
         if (aw_hs) begin
            check("aw_addr", m_awaddr, 4);
            ops.push_back(1);
            n_wr++;
         end
         if (w_hs) begin
            check("w_strb", m_wstrb, 4'b0001);
            if (exp_tx.size() == 0) check("w_unexpected", 1, 0);
            else check("w_data", m_wdata, {24'h0, exp_tx[0]});
            $display("tx_write data=0x%08h strb=%04b", m_wdata, m_wstrb);
         end
         if (b_hs && exp_tx.size() != 0) exp_tx.pop_front();
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 0;
      exp_rx.delete(); exp_tx.delete(); ops.delete();
      tick(2);
      RST_N = 1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 500) begin tick(1); n++; end
      check("push_tx_ready", tx_ready, 1);
      tx_data = b; tx_valid = 1;
      exp_tx.push_back(b);
      tick(1);
      tx_valid = 0;
   endtask

   task automatic wait_tx_drained(input string tag);
      int n = 0;
      while (exp_tx.size() != 0 && n < 3000) begin tick(1); n++; end
      check(tag, exp_tx.size(), 0);
   endtask

   task automatic pop_rx();
      int n = 0;
      while (!rx_valid && n < 500) begin tick(1); n++; end
      check("pop_rx_valid", rx_valid, 1);
      if (rx_valid && exp_rx.size() != 0) begin
         check("rx_data", rx_data, exp_rx[0]);
         rx_ready = 1;
         tick(1);
         rx_ready = 0;
         exp_rx.pop_front();
      end
   endtask

   initial begin
      int w0, s0, n;
      RST_N = 0; rx_ready = 0; tx_valid = 0; tx_data = 0;
      tick(2);
      // reset state
      check("rst_arvalid", m_arvalid, 0);
      check("rst_rready", m_rready, 0);
      check("rst_awvalid", m_awvalid, 0);
      check("rst_wvalid", m_wvalid, 0);
      check("rst_bready", m_bready, 0);
      check("rst_araddr", m_araddr, 0);
      check("rst_wdata", m_wdata, 0);
      check("rst_err", err, 0);
      RST_N = 1;
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 1);

      // plain TX writes with status 0x00
      w0 = n_wr;
      push_tx(8'h10); push_tx(8'h11); push_tx(8'h12);
      for (int i = 0; i < 6; i++) push_tx(8'($urandom_range(0, 255)));
      wait_tx_drained("tx_drain_basic");
      check("tx_write_count", n_wr - w0, 9);
      check("tx_no_rx_reads", n_rxrd, 0);

      // TX FIFO full flag in UART status blocks writes; bytes stay queued
      status_cfg = 8'h08;
      tick(20);
      w0 = n_wr;
      for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(0, 255)));
      s0 = n_status;
      tick(200);
      check("blocked_no_aw", n_wr - w0, 0);
      check("blocked_polls", 32'((n_status - s0) >= 10), 1);
      check("blocked_tx_ready", tx_ready, 1);
      status_cfg = 8'h00;
      wait_tx_drained("tx_drain_after_block");
      check("unblocked_writes", n_wr - w0, 4);

      // RX/TX arbitration from reset, then fill RX FIFO
      slave_en = 0; status_cfg = 8'h01;
      do_reset();
      n_rxrd = 0; w0 = n_wr;
      push_tx(8'($urandom_range(0, 255)));
      push_tx(8'($urandom_range(0, 255)));
      push_tx(8'($urandom_range(0, 255)));
      first_rx = 1; slave_en = 1;
      n = 0;
      while (n_rxrd < DEPTH && n < 3000) begin tick(1); n++; end
      check("rx_fill_reads", n_rxrd, DEPTH);
      for (int i = 0; i < 6; i++) begin
         if (i < ops.size()) check("rr_order", ops[i], i % 2);
         else check("rr_order_missing", ops.size(), 6);
      end
      tick(100);
      check("rx_full_no_more_reads", n_rxrd, DEPTH);
      check("rx_full_writes", n_wr - w0, 3);
      check("rx_full_valid", rx_valid, 1);
      check("rx_first_byte", rx_data, 8'h41);
      status_cfg = 8'h00;
      for (int i = 0; i < DEPTH; i++) pop_rx();
      tick(5);
      check("rx_drained", rx_valid, 0);

      // error response: sticky err, byte still consumed, no retry
      bresp_cfg = 2'b10; w0 = n_wr;
      push_tx(8'($urandom_range(0, 255)));
      wait_tx_drained("tx_drain_err");
      check("err_set", err, 1);
      tick(30);
      check("err_held", err, 1);
      check("err_no_retry", n_wr - w0, 1);
      bresp_cfg = 2'b00;

      // reset in the middle of a write
      wr_hold = 1;
      push_tx(8'($urandom_range(0, 255)));
      n = 0;
      while (!m_awvalid && n < 200) begin tick(1); n++; end
      check("txw_reached", m_awvalid, 1);
      RST_N = 0;
      exp_rx.delete(); exp_tx.delete(); ops.delete();
      tick(1);
      check("abort_awvalid", m_awvalid, 0);
      check("abort_wvalid", m_wvalid, 0);
      check("abort_arvalid", m_arvalid, 0);
      check("abort_bready", m_bready, 0);
      check("abort_err", err, 0);
      wr_hold = 0;
      tick(1);
      RST_N = 1;
      check("abort_rx_valid", rx_valid, 0);
      check("abort_tx_ready", tx_ready, 1);
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
